// File: rtl/sp_ram_bank_array.sv
// Banked single-port RAM: NUM_BANKS sp_ram macros behind a req/gnt/rvalid port,
// contiguous or word-interleaved bank mapping, optional output register and post-reset zero-fill.

module sp_ram #(
    parameter  int unsigned WORDS      = 4096,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned ROW_W      = 12,
    localparam int unsigned BE_W       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ROW_W-1:0]      addr,
    input  logic [BE_W-1:0]       be,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

module sp_ram_bank_array #(
    parameter  int unsigned RAM_SIZE   = 65536,
    parameter  int unsigned NUM_BANKS  = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned INTERLEAVE = 0,
    parameter  int unsigned OUT_REG    = 0,
    parameter  int unsigned INIT_ZERO  = 1,
    localparam int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    localparam int unsigned BE_W       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [BE_W-1:0]       be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  init_done_o
);
    localparam int unsigned WORD_OFF   = $clog2(BE_W);
    localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
    localparam int unsigned BANK_WORDS = RAM_SIZE / (BE_W * NUM_BANKS);
    localparam int unsigned ROW_W      = $clog2(BANK_WORDS);
    localparam int unsigned BIDX_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BANK_WORDS - 1);

    if (NUM_BANKS == 0 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_num_banks
        $fatal(1, "sp_ram_bank_array: NUM_BANKS must be a power of 2");
    end
    if (DATA_WIDTH == 0 || DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $fatal(1, "sp_ram_bank_array: DATA_WIDTH must be a multiple of 8");
    end
    if (RAM_SIZE % (BE_W * NUM_BANKS) != 0) begin : g_bad_ram_size
        $fatal(1, "sp_ram_bank_array: RAM_SIZE must be divisible by BE_W*NUM_BANKS");
    end
    if (BANK_WORDS < 2) begin : g_bad_bank_words
        $fatal(1, "sp_ram_bank_array: each bank needs at least 2 words");
    end

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      init_row_q, init_row_d;
    logic                  accept;
    logic [BIDX_W-1:0]     bank_sel;
    logic [ROW_W-1:0]      row_sel;
    logic [NUM_BANKS-1:0]  ram_en;
    logic                  ram_we;
    logic [BE_W-1:0]       ram_be;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [ROW_W-1:0]      ram_row;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic                  valid_q;
    logic                  is_read_q;
    logic [BIDX_W-1:0]     bank_q;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  unused_addr_bits;

    // Byte-offset bits never select anything; referenced here so every address bit is consumed.
    assign unused_addr_bits = ^{1'b0, addr_i};

    if (NUM_BANKS == 1) begin : g_map_single
        assign bank_sel = '0;
        assign row_sel  = addr_i[ADDR_WIDTH-1:WORD_OFF];
    end else if (INTERLEAVE != 0) begin : g_map_interleave
        assign bank_sel = addr_i[WORD_OFF +: BANK_BITS];
        assign row_sel  = addr_i[ADDR_WIDTH-1:WORD_OFF+BANK_BITS];
    end else begin : g_map_contiguous
        assign bank_sel = addr_i[ADDR_WIDTH-1 -: BANK_BITS];
        assign row_sel  = addr_i[ADDR_WIDTH-BANK_BITS-1:WORD_OFF];
    end

    assign init_done_o = (state_q == ST_READY) && !rst_i;

    always_comb begin
        state_d    = state_q;
        init_row_d = init_row_q;
        gnt_o      = 1'b0;
        accept     = 1'b0;
        ram_en     = '0;
        ram_we     = 1'b0;
        ram_be     = '0;
        ram_wdata  = '0;
        ram_row    = '0;
        case (state_q)
            ST_INIT: begin
                // Every bank clears the same row in parallel.
                ram_en     = '1;
                ram_we     = 1'b1;
                ram_be     = '1;
                ram_row    = init_row_q;
                init_row_d = init_row_q + 1'b1;
                if (init_row_q == ROW_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                gnt_o     = req_i && !rst_i;
                accept    = gnt_o;
                ram_we    = we_i;
                ram_be    = be_i;
                ram_wdata = wdata_i;
                ram_row   = row_sel;
                for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                    ram_en[b] = accept && (bank_sel == BIDX_W'(b));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            init_row_q <= '0;
        end else begin
            state_q    <= state_d;
            init_row_q <= init_row_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sp_ram #(
            .WORDS     (BANK_WORDS),
            .DATA_WIDTH(DATA_WIDTH),
            .ROW_W     (ROW_W)
        ) u_ram (
            .clk  (clk),
            .en   (ram_en[b]),
            .we   (ram_we),
            .addr (ram_row),
            .be   (ram_be),
            .wdata(ram_wdata),
            .rdata(bank_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            is_read_q <= 1'b0;
            bank_q    <= '0;
        end else begin
            valid_q   <= accept;
            is_read_q <= accept && !we_i;
            if (accept) begin
                bank_q <= bank_sel;
            end
        end
    end

    // Each bank's read register holds until its next read, so bank_q picks the right one.
    always_comb begin
        resp_rdata = '0;
        if (valid_q && is_read_q) begin
            resp_rdata = bank_rdata[bank_q];
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  out_valid_q;
        logic [DATA_WIDTH-1:0] out_rdata_q;

        always_ff @(posedge clk) begin
            if (rst_i) begin
                out_valid_q <= 1'b0;
                out_rdata_q <= '0;
            end else begin
                out_valid_q <= valid_q;
                out_rdata_q <= resp_rdata;
            end
        end

        assign rvalid_o = out_valid_q;
        assign rdata_o  = out_rdata_q;
    end else begin : g_out_direct
        assign rvalid_o = valid_q;
        assign rdata_o  = resp_rdata;
    end
endmodule

// File: tb/tb_sp_ram_bank_array.sv
// Scoreboard bench for sp_ram_bank_array: default instance (contiguous, zero-fill) and an
// interleaved OUT_REG instance without zero-fill; responses checked for data and arrival cycle.

module tb_sp_ram_bank_array;
    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned total  = 0;
    int unsigned passed = 0;
    bit          mon_on = 1'b0;

    exp_t qa[$];
    exp_t qb[$];

    logic        rst_a = 1'b1, req_a = 1'b0, we_a = 1'b0;
    logic [15:0] addr_a = '0;
    logic [3:0]  be_a = '0;
    logic [31:0] wdata_a = '0;
    logic        gnt_a, rvalid_a, init_done_a;
    logic [31:0] rdata_a;

    logic        rst_b = 1'b1, req_b = 1'b0, we_b = 1'b0;
    logic [15:0] addr_b = '0;
    logic [3:0]  be_b = '0;
    logic [31:0] wdata_b = '0;
    logic        gnt_b, rvalid_b, init_done_b;
    logic [31:0] rdata_b;

    sp_ram_bank_array dut_a (
        .clk(clk), .rst_i(rst_a), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr_a),
        .we_i(we_a), .be_i(be_a), .wdata_i(wdata_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .init_done_o(init_done_a)
    );

    sp_ram_bank_array #(
        .INTERLEAVE(1),
        .OUT_REG   (1),
        .INIT_ZERO (0)
    ) dut_b (
        .clk(clk), .rst_i(rst_b), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr_b),
        .we_i(we_b), .be_i(be_b), .wdata_i(wdata_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .init_done_o(init_done_b)
    );

    exp_t ea;
    always @(negedge clk) begin
        if (mon_on) begin
            total++;
            if (rvalid_a === 1'b1) begin
                if (qa.size() == 0) begin
                    $display("FAIL a_unexpected_rvalid: rvalid_o=1 rdata_o=%h at cycle %0d, required no response", rdata_a, cyc);
                end else begin
                    ea = qa.pop_front();
                    if (rdata_a !== ea.data || cyc != ea.due)
                        $display("FAIL a_response: rdata_o=%h at cycle %0d, required %h at cycle %0d", rdata_a, cyc, ea.data, ea.due);
                    else passed++;
                end
            end else if (rvalid_a !== 1'b0 || rdata_a !== 32'h0) begin
                $display("FAIL a_idle: rvalid_o=%b rdata_o=%h at cycle %0d, required 0/00000000", rvalid_a, rdata_a, cyc);
            end else passed++;
        end
    end

    exp_t eb;
    always @(negedge clk) begin
        if (mon_on) begin
            total++;
            if (rvalid_b === 1'b1) begin
                if (qb.size() == 0) begin
                    $display("FAIL b_unexpected_rvalid: rvalid_o=1 rdata_o=%h at cycle %0d, required no response", rdata_b, cyc);
                end else begin
                    eb = qb.pop_front();
                    if (rdata_b !== eb.data || cyc != eb.due)
                        $display("FAIL b_response: rdata_o=%h at cycle %0d, required %h at cycle %0d", rdata_b, cyc, eb.data, eb.due);
                    else passed++;
                end
            end else if (rvalid_b !== 1'b0 || rdata_b !== 32'h0) begin
                $display("FAIL b_idle: rvalid_o=%b rdata_o=%h at cycle %0d, required 0/00000000", rvalid_b, rdata_b, cyc);
            end else passed++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one access on dut_a and record its response (latency 1).
    task automatic drive_a(input logic w, input logic [15:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] ex);
        req_a = 1'b1; we_a = w; addr_a = a; be_a = be; wdata_a = wd;
        qa.push_back('{data: ex, due: cyc + 1});
    endtask

    // Drive one access on dut_b and record its response (latency 2).
    task automatic drive_b(input logic w, input logic [15:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] ex);
        req_b = 1'b1; we_b = w; addr_b = a; be_b = be; wdata_b = wd;
        qb.push_back('{data: ex, due: cyc + 2});
    endtask

    task automatic idle_a();
        req_a = 1'b0; we_a = 1'b0;
    endtask

    task automatic idle_b();
        req_b = 1'b0; we_b = 1'b0;
    endtask

    task automatic test_reset();
        int unsigned bad = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0000;
        req_b = 1'b1; we_b = 1'b0; addr_b = 16'h0000;
        step();
        mon_on = 1'b1;
        @(negedge clk);
        total++;
        if (gnt_a !== 1'b0 || init_done_a !== 1'b0 || rvalid_a !== 1'b0 || rdata_a !== 32'h0)
            $display("FAIL reset_a: gnt=%b init_done=%b rvalid=%b rdata=%h, required 0 0 0 0", gnt_a, init_done_a, rvalid_a, rdata_a);
        else passed++;
        total++;
        if (gnt_b !== 1'b0 || init_done_b !== 1'b0 || rvalid_b !== 1'b0 || rdata_b !== 32'h0)
            $display("FAIL reset_b: gnt=%b init_done=%b rvalid=%b rdata=%h, required 0 0 0 0", gnt_b, init_done_b, rvalid_b, rdata_b);
        else passed++;
        step();
        rst_a = 1'b0; rst_b = 1'b0; idle_b();
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (init_done_b !== 1'b1)
                    $display("FAIL b_no_init_ready: init_done_o=%b, required 1", init_done_b);
                else passed++;
            end
            if (gnt_a !== 1'b0 || init_done_a !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL init_hold: %0d of 4096 cycles with gnt/init_done high, required 0", bad);
        else passed++;
        step();
        drive_a(1'b0, 16'h0000, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        total++;
        if (gnt_a !== 1'b1 || init_done_a !== 1'b1)
            $display("FAIL init_end: gnt=%b init_done=%b, required 1 1", gnt_a, init_done_a);
        else passed++;
        step();
        drive_a(1'b0, 16'h4000, 4'h0, 32'h0, 32'h0); step();
        drive_a(1'b0, 16'h8000, 4'h0, 32'h0, 32'h0); step();
        drive_a(1'b0, 16'hFFFC, 4'h0, 32'h0, 32'h0); step();
        idle_a();
        repeat (3) step();
        total++;
        if (qa.size() != 0) $display("FAIL reset_reads_drain: %0d responses missing, required 0", qa.size());
        else passed++;
    endtask

    task automatic test_contiguous();
        logic [15:0] ad [4] = '{16'h0004, 16'hC004, 16'h0004, 16'hC004};
        logic [31:0] dt [4] = '{32'hA5A5_0001, 32'hA5A5_0003, 32'hA5A5_0001, 32'hA5A5_0003};
        logic [3:0]  en [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            if (i < 2) drive_a(1'b1, ad[i], 4'hF, dt[i], 32'h0);
            else       drive_a(1'b0, ad[i], 4'h0, 32'h0, dt[i]);
            @(negedge clk);
            total++;
            if (dut_a.ram_en !== en[i])
                $display("FAIL contig_bank_en[%0d]: en=%b, required %b", i, dut_a.ram_en, en[i]);
            else passed++;
            step();
        end
        idle_a();
        repeat (3) step();
        total++;
        if (qa.size() != 0) $display("FAIL contig_drain: %0d responses missing, required 0", qa.size());
        else passed++;
    endtask

    task automatic test_interleave();
        logic [3:0] want;
        for (int i = 0; i < 16; i++) begin
            int k = (i < 8) ? i : 15 - i;
            if (i < 8) drive_b(1'b1, 16'(k * 4), 4'hF, 32'hB000_0000 + k, 32'h0);
            else       drive_b(1'b0, 16'(k * 4), 4'h0, 32'h0, 32'hB000_0000 + k);
            want = 4'b0001 << (k % 4);
            @(negedge clk);
            total++;
            if (dut_b.ram_en !== want || gnt_b !== 1'b1)
                $display("FAIL ilv_bank_en[%0d]: en=%b gnt=%b, required %b 1", i, dut_b.ram_en, gnt_b, want);
            else passed++;
            step();
        end
        idle_b();
        repeat (4) step();
        total++;
        if (qb.size() != 0) $display("FAIL ilv_drain: %0d responses missing, required 0", qb.size());
        else passed++;
    endtask

    task automatic test_byte_enables();
        drive_a(1'b1, 16'h0100, 4'hF, 32'hFFFF_FFFF, 32'h0); step();
        drive_a(1'b1, 16'h0100, 4'b0101, 32'h1122_3344, 32'h0); step();
        drive_a(1'b0, 16'h0100, 4'h0, 32'h0, 32'hFF22_FF44); step();
        idle_a();
        repeat (3) step();
        total++;
        if (qa.size() != 0) $display("FAIL be_drain: %0d responses missing, required 0", qa.size());
        else passed++;
    endtask

    task automatic test_out_reg();
        for (int j = 0; j < 4; j++) begin
            drive_b(1'b1, 16'(16'h0200 + 4 * j), 4'hF, 32'hC0DE_0000 + 32'(j) * 32'h0101, 32'h0);
            step();
            drive_b(1'b0, 16'(16'h0200 + 4 * j), 4'h0, 32'h0, 32'hC0DE_0000 + 32'(j) * 32'h0101);
            step();
        end
        idle_b();
        repeat (4) step();
        total++;
        if (qb.size() != 0) $display("FAIL outreg_drain: %0d responses missing, required 0", qb.size());
        else passed++;
    endtask

    task automatic test_reset_inflight_a();
        int unsigned rc;
        int unsigned bad = 0;
        drive_a(1'b0, 16'h0004, 4'h0, 32'h0, 32'hA5A5_0001); step();
        drive_a(1'b0, 16'h0100, 4'h0, 32'h0, 32'hFF22_FF44); step();
        idle_a();
        rst_a = 1'b1; rc = cyc;
        step();
        rst_a = 1'b0;
        while (qa.size() > 0 && qa[$].due > rc) void'(qa.pop_back());
        req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0004;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            if (gnt_a !== 1'b0 || init_done_a !== 1'b0 || rvalid_a !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL reinit_hold: %0d of 4096 cycles with gnt/init_done/rvalid high, required 0", bad);
        else passed++;
        step();
        drive_a(1'b0, 16'h0004, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        total++;
        if (gnt_a !== 1'b1 || init_done_a !== 1'b1)
            $display("FAIL reinit_end: gnt=%b init_done=%b, required 1 1", gnt_a, init_done_a);
        else passed++;
        step();
        drive_a(1'b0, 16'h0100, 4'h0, 32'h0, 32'h0); step();
        drive_a(1'b0, 16'hC004, 4'h0, 32'h0, 32'h0); step();
        idle_a();
        repeat (3) step();
        total++;
        if (qa.size() != 0) $display("FAIL reinit_drain: %0d responses missing, required 0", qa.size());
        else passed++;
    endtask

    task automatic test_reset_inflight_b();
        int unsigned rc;
        drive_b(1'b0, 16'h0200, 4'h0, 32'h0, 32'hC0DE_0000); step();
        drive_b(1'b0, 16'h0204, 4'h0, 32'h0, 32'hC0DE_0101); step();
        idle_b();
        rst_b = 1'b1; rc = cyc;
        step();
        rst_b = 1'b0;
        while (qb.size() > 0 && qb[$].due > rc) void'(qb.pop_back());
        drive_b(1'b0, 16'h0200, 4'h0, 32'h0, 32'hC0DE_0000);
        @(negedge clk);
        total++;
        if (rvalid_b !== 1'b0 || init_done_b !== 1'b1 || gnt_b !== 1'b1)
            $display("FAIL b_reset_drop: rvalid=%b init_done=%b gnt=%b, required 0 1 1", rvalid_b, init_done_b, gnt_b);
        else passed++;
        step();
        idle_b();
        repeat (4) step();
        total++;
        if (qb.size() != 0) $display("FAIL b_reset_drain: %0d responses missing, required 0", qb.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_interleave();
        test_byte_enables();
        test_out_reg();
        test_reset_inflight_a();
        test_reset_inflight_b();
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
